visualizador_suma: RTL and testbench
====================================

VISUALIZADOR_SUMA -- requirements
Module: visualizador_suma

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving the refresh prescaler period in clk cycles per digit slot (legal range DIV >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port zi, input, 4 bits: sum bits from the upstream 4-bit adder.
REQ-005 The block SHALL have port co, input, 1 bit: carry-out from the upstream adder, weight 16.
REQ-006 The block SHALL have port cargar, input, 1 bit: capture strobe, active-high, level-sampled each clock.
REQ-007 The block SHALL have port valor, output, 5 bits: captured result {co,zi}, 0..31.
REQ-008 The block SHALL have port listo, output, 1 bit: high once at least one value has been captured since reset.
REQ-009 The block SHALL have port sseg, output, 7 bits: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port an, output, 4 bits: active-low digit anodes; an[0] is units, an[1] is tens, an[3:2] always 1.

Function
REQ-011 Capture SHALL occur on each clock with cargar=1: valor <= {co,zi}, listo <= 1, with the new value visible on the next cycle.
REQ-012 Decode SHALL give tens = valor/10 (0..3) and units = valor%10, both combinational from valor.
REQ-013 The prescaler SHALL count 0..DIV-1, wrap to 0, and assert an internal tick for one cycle when count==DIV-1.
REQ-014 The FSM SHALL have exactly the states BLANK, SCAN_U and SCAN_D.
REQ-015 The FSM SHALL go from BLANK to SCAN_U on cargar=1, clearing the prescaler to 0 on the same edge; otherwise it stays in BLANK and the prescaler holds 0.
REQ-016 The FSM SHALL go from SCAN_U to SCAN_D on tick, and from SCAN_D to SCAN_U on tick; with no tick the state holds.
REQ-017 cargar in SCAN_U or SCAN_D SHALL update valor only; the state and prescaler SHALL be unaffected.
REQ-018 In BLANK the outputs SHALL be an=1111 and sseg=1111111.
REQ-019 In SCAN_U the outputs SHALL be an=1110 and sseg=seg(units).
REQ-020 In SCAN_D with tens!=0 the outputs SHALL be an=1101 and sseg=seg(tens).
REQ-021 In SCAN_D with tens==0 (leading-zero blanking) the outputs SHALL be an=1111 and sseg=1111111.
REQ-022 The seg() table SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 sseg and an SHALL be combinational from the registered state and valor only, with no combinational path from zi, co or cargar.
REQ-024 At any instant at most one anode SHALL be low.
REQ-025 The prescaler width SHALL be $clog2(DIV) bits, with no overflow beyond DIV-1.

Reset
REQ-026 rst=1 SHALL force state=BLANK, prescaler=0, valor=00000 and listo=0, giving an=1111 and sseg=1111111 on the following cycle.
REQ-027 rst SHALL have priority over cargar and tick when asserted in the same cycle.
REQ-028 rst asserted mid-scan SHALL abort the scan with no residual digit output on the cycle after reset.
REQ-029 After rst deasserts, the block SHALL remain in BLANK until the first cargar.

Verification (bench uses DIV=4)
REQ-030 Reset then idle 20 cycles -> an=1111, sseg=1111111, listo=0, valor=0 throughout.
REQ-031 co=1, zi=1011, cargar pulse -> valor=11011 (27), listo=1, an=1110 with sseg=1111000 for 4 cycles, then an=1101 with sseg=0100100 for 4 cycles, repeating.
REQ-032 co=0, zi=0101 load -> SCAN_U shows an=1110, sseg=0010010; SCAN_D slot shows an=1111, sseg=1111111 (tens blanked).
REQ-033 co=1, zi=1111 (31) load, then co=0, zi=1001 (9) loaded with cargar while in SCAN_D at prescaler=1 -> next cycle an=1111 blanked, slot ends on schedule at prescaler wrap, then SCAN_U shows sseg=0010000.
REQ-034 rst asserted together with cargar while in SCAN_D -> next cycle state BLANK, valor=0, listo=0, an=1111.
REQ-035 Every cycle, the bench SHALL check that an has at most one zero bit and that an[3:2]==11.

Source files
------------

// File: rtl/visualizador_suma.sv
// Purpose : captures a 5-bit adder result {co,zi} and shows it on two multiplexed 7-segment digits.
// Latency : a capture is visible on valor/listo the cycle after cargar; the display follows the registered value.
// Backpressure: none; cargar is accepted on every clock and simply overwrites the held value.
//
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   zi, co        - sum bits and carry-out from the upstream adder (weight of co is 16)
//   cargar        - capture strobe, level-sampled each clock
//   valor, listo  - held value 0..31 and "something has been captured since reset"
//   sseg, an      - active-low segments {g,f,e,d,c,b,a} and active-low anodes (an[0] units, an[1] tens)
module visualizador_suma #(
    parameter int DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] zi,
    input  logic       co,
    input  logic       cargar,
    output logic [4:0] valor,
    output logic       listo,
    output logic [6:0] sseg,
    output logic [3:0] an
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SCAN_U = 2'd1,
        SCAN_D = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    valor_q, valor_d;
    logic          listo_q, listo_d;
    logic          tick;

    // One-cycle strobe at the end of each digit slot.
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valor_d = valor_q;
        listo_d = listo_q;

        // Capture is independent of the scan; while scanning it never disturbs the slot timing.
        if (cargar) begin
            valor_d = {co, zi};
            listo_d = 1'b1;
        end

        case (state_q)
            BLANK: begin
                // Prescaler parked at 0 so the first units slot after a load is a full DIV cycles.
                cnt_d = '0;
                if (cargar) begin
                    state_d = SCAN_U;
                end
            end
            SCAN_U: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    state_d = SCAN_D;
                end
            end
            SCAN_D: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    state_d = SCAN_U;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            valor_q <= '0;
            listo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valor_q <= valor_d;
            listo_q <= listo_d;
        end
    end

    // Decimal split of 0..31 without a divider: tens is at most 3.
    logic [1:0] tens;
    logic [4:0] units;

    always_comb begin
        if (valor_q >= 5'd30) begin
            tens = 2'd3;
        end else if (valor_q >= 5'd20) begin
            tens = 2'd2;
        end else if (valor_q >= 5'd10) begin
            tens = 2'd1;
        end else begin
            tens = 2'd0;
        end
        units = valor_q - 5'(tens) * 5'd10;
    end

    function automatic logic [6:0] seg7(input logic [4:0] digit);
        case (digit)
            5'd0:    seg7 = 7'b1000000;
            5'd1:    seg7 = 7'b1111001;
            5'd2:    seg7 = 7'b0100100;
            5'd3:    seg7 = 7'b0110000;
            5'd4:    seg7 = 7'b0011001;
            5'd5:    seg7 = 7'b0010010;
            5'd6:    seg7 = 7'b0000010;
            5'd7:    seg7 = 7'b1111000;
            5'd8:    seg7 = 7'b0000000;
            5'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Display driven only from registered state and value, so no input reaches sseg/an combinationally.
    always_comb begin
        an   = 4'b1111;
        sseg = 7'b1111111;
        case (state_q)
            SCAN_U: begin
                an   = 4'b1110;
                sseg = seg7(units);
            end
            SCAN_D: begin
                // Leading zero on the tens digit is blanked rather than shown.
                if (tens != 2'd0) begin
                    an   = 4'b1101;
                    sseg = seg7(5'(tens));
                end
            end
            default: begin
                an   = 4'b1111;
                sseg = 7'b1111111;
            end
        endcase
    end

    assign valor = valor_q;
    assign listo = listo_q;

endmodule

// File: tb/tb_visualizador_suma.sv
module tb_visualizador_suma;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic [3:0] zi;
    logic       co;
    logic       cargar;
    logic [4:0] valor;
    logic       listo;
    logic [6:0] sseg;
    logic [3:0] an;

    int errors = 0;
    int checks = 0;

    visualizador_suma #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .zi    (zi),
        .co    (co),
        .cargar(cargar),
        .valor (valor),
        .listo (listo),
        .sseg  (sseg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whether a scan is running, cycles elapsed since it started,
    // and the held value. Slot k of the scan lasts DIV cycles; even slots show units.
    bit m_scan;
    int m_el;
    int m_valor;
    bit m_listo;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tab[d];
    endfunction

    function automatic logic [3:0] exp_an();
        if (!m_scan) return 4'b1111;
        if (((m_el / DIV) % 2) == 0) return 4'b1110;
        return (m_valor / 10 != 0) ? 4'b1101 : 4'b1111;
    endfunction

    function automatic logic [6:0] exp_sseg();
        if (!m_scan) return 7'b1111111;
        if (((m_el / DIV) % 2) == 0) return seg_of(m_valor % 10);
        return (m_valor / 10 != 0) ? seg_of(m_valor / 10) : 7'b1111111;
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, then settle past the edge.
    task automatic step(input logic r, input logic c, input logic cin, input logic [3:0] z);
        rst    = r;
        cargar = c;
        co     = cin;
        zi     = z;
        @(posedge clk);
        if (r) begin
            m_scan  = 0;
            m_el    = 0;
            m_valor = 0;
            m_listo = 0;
        end else begin
            if (m_scan) m_el++;
            if (c) begin
                m_valor = {27'd0, cin, z};
                m_listo = 1;
                if (!m_scan) begin
                    m_scan = 1;
                    m_el   = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 4'h0);
        step(1, 1, 1, 4'hF);
        if (an !== 4'b1111 || sseg !== 7'b1111111 || valor !== 5'd0 || listo !== 1'b0) begin
            errors++;
            $display("FAIL reset_state an=%b sseg=%b valor=%0d listo=%b expected 1111 1111111 0 0", an, sseg, valor, listo);
        end
        checks++;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1'($urandom), 4'($urandom));
            if (an !== 4'b1111 || sseg !== 7'b1111111 || valor !== 5'd0 || listo !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d an=%b sseg=%b valor=%0d listo=%b expected 1111 1111111 0 0", i, an, sseg, valor, listo);
            end
            checks++;
        end
    endtask

    task automatic test_load_27();
        step(0, 1, 1, 4'b1011);
        if (valor !== 5'd27 || listo !== 1'b1) begin
            errors++;
            $display("FAIL load27_value valor=%0d listo=%b expected 27 1", valor, listo);
        end
        checks++;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ea;
            logic [6:0] es;
            ea = (((i % 8) < 4) ? 4'b1110 : 4'b1101);
            es = (((i % 8) < 4) ? 7'b1111000 : 7'b0100100);
            if (an !== ea || sseg !== es) begin
                errors++;
                $display("FAIL load27_scan cyc=%0d an=%b sseg=%b expected an=%b sseg=%b", i, an, sseg, ea, es);
            end
            checks++;
            if (an[3:2] !== 2'b11 || $countones(~an) > 1) begin
                errors++;
                $display("FAIL load27_anode cyc=%0d an=%b", i, an);
            end
            checks++;
            step(0, 0, 0, 4'h0);
        end
    endtask

    task automatic test_load_5();
        step(1, 0, 0, 4'h0);
        step(0, 1, 0, 4'b0101);
        for (int i = 0; i < 16; i++) begin
            if (an !== exp_an() || sseg !== exp_sseg() || valor !== 5'd5) begin
                errors++;
                $display("FAIL load5_scan cyc=%0d an=%b sseg=%b valor=%0d expected an=%b sseg=%b valor=5",
                         i, an, sseg, valor, exp_an(), exp_sseg());
            end
            checks++;
            if (an[3:2] !== 2'b11 || $countones(~an) > 1) begin
                errors++;
                $display("FAIL load5_anode cyc=%0d an=%b", i, an);
            end
            checks++;
            step(0, 0, 0, 4'h0);
        end
    endtask

    task automatic test_reload_in_scan_d();
        step(1, 0, 0, 4'h0);
        step(0, 1, 1, 4'hF);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 4'h0);
        if (an !== 4'b1101 || sseg !== 7'b0110000) begin
            errors++;
            $display("FAIL reload_before an=%b sseg=%b expected 1101 0110000", an, sseg);
        end
        checks++;
        step(0, 1, 0, 4'b1001);
        for (int i = 0; i < 2; i++) begin
            if (an !== 4'b1111 || sseg !== 7'b1111111 || valor !== 5'd9) begin
                errors++;
                $display("FAIL reload_blank cyc=%0d an=%b sseg=%b valor=%0d expected 1111 1111111 9", i, an, sseg, valor);
            end
            checks++;
            step(0, 0, 0, 4'h0);
        end
        if (an !== 4'b1110 || sseg !== 7'b0010000) begin
            errors++;
            $display("FAIL reload_units an=%b sseg=%b expected 1110 0010000", an, sseg);
        end
        checks++;
    endtask

    task automatic test_reset_with_cargar();
        step(1, 0, 0, 4'h0);
        step(0, 1, 1, 4'b1001);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 4'h0);
        if (an !== 4'b1101 || sseg !== 7'b0100100) begin
            errors++;
            $display("FAIL rstcar_before an=%b sseg=%b expected 1101 0100100", an, sseg);
        end
        checks++;
        step(1, 1, 1, 4'hF);
        if (an !== 4'b1111 || sseg !== 7'b1111111 || valor !== 5'd0 || listo !== 1'b0) begin
            errors++;
            $display("FAIL rstcar_after an=%b sseg=%b valor=%0d listo=%b expected 1111 1111111 0 0", an, sseg, valor, listo);
        end
        checks++;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 4'hA);
            if (an !== 4'b1111 || listo !== 1'b0) begin
                errors++;
                $display("FAIL rstcar_idle cyc=%0d an=%b listo=%b expected 1111 0", i, an, listo);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom));
            if (an !== exp_an() || sseg !== exp_sseg()) begin
                errors++;
                $display("FAIL rand_disp cyc=%0d an=%b sseg=%b expected an=%b sseg=%b", i, an, sseg, exp_an(), exp_sseg());
            end
            checks++;
            if (valor !== 5'(m_valor) || listo !== m_listo) begin
                errors++;
                $display("FAIL rand_value cyc=%0d valor=%0d listo=%b expected valor=%0d listo=%b", i, valor, listo, m_valor, m_listo);
            end
            checks++;
            if (an[3:2] !== 2'b11 || $countones(~an) > 1) begin
                errors++;
                $display("FAIL rand_anode cyc=%0d an=%b", i, an);
            end
            checks++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        cargar  = 1'b0;
        co      = 1'b0;
        zi      = 4'h0;
        m_scan  = 0;
        m_el    = 0;
        m_valor = 0;
        m_listo = 0;
        #1;
        test_reset();
        test_load_27();
        test_load_5();
        test_reload_in_scan_d();
        test_reset_with_cargar();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
